// File: rtl/rx_sync_fifo.sv
// Synchronous RX FIFO: storage, pointers, occupancy, status and sticky error flags.
// Read side is either registered (1-cycle latency) or first-word-fall-through.
module rx_sync_fifo #(
  parameter int unsigned DATA_WIDTH = 12,
  parameter int unsigned FIFO_DEPTH = 32,
  parameter int unsigned FWFT       = 0,
  parameter int unsigned AFULL_LVL  = 28,
  parameter int unsigned AEMPTY_LVL = 4,
  localparam int unsigned ADDR_W    = $clog2(FIFO_DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush_i,
  input  logic                  err_clr_i,
  input  logic                  wr_en_i,
  input  logic [DATA_WIDTH-1:0] wr_data_i,
  input  logic                  rd_en_i,
  output logic [DATA_WIDTH-1:0] rd_data_o,
  output logic                  rd_valid_o,
  output logic                  full_o,
  output logic                  empty_o,
  output logic                  almost_full_o,
  output logic                  almost_empty_o,
  output logic [ADDR_W:0]       count_o,
  output logic                  overflow_o,
  output logic                  underflow_o
);

  localparam logic [ADDR_W:0] DepthCnt  = (ADDR_W+1)'(FIFO_DEPTH);
  localparam logic [ADDR_W:0] AfullCnt  = (ADDR_W+1)'(AFULL_LVL);
  localparam logic [ADDR_W:0] AemptyCnt = (ADDR_W+1)'(AEMPTY_LVL);
  localparam logic [ADDR_W:0] PtrOne    = (ADDR_W+1)'(1);

  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];

  logic [ADDR_W:0] wptr_q, wptr_d;
  logic [ADDR_W:0] rptr_q, rptr_d;
  logic [ADDR_W:0] count;
  logic            ovf_q, ovf_d;
  logic            udf_q, udf_d;
  logic            full, empty;
  logic            wr_acc, rd_acc;
  logic [ADDR_W-1:0] waddr, raddr;

  // Occupancy and flags decode from registered pointers only; the extra pointer
  // bit makes the difference span 0..FIFO_DEPTH without a separate counter.
  always_comb begin
    count = wptr_q - rptr_q;
    full  = (count == DepthCnt);
    empty = (count == '0);
    waddr = wptr_q[ADDR_W-1:0];
    raddr = rptr_q[ADDR_W-1:0];
  end

  // Accept decisions, pointer advance and sticky error flags.
  always_comb begin
    wr_acc = wr_en_i & ~full & ~flush_i;
    rd_acc = rd_en_i & ~empty & ~flush_i;
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    ovf_d  = ovf_q;
    udf_d  = udf_q;
    if (flush_i) begin
      wptr_d = '0;
      rptr_d = '0;
      ovf_d  = 1'b0;
      udf_d  = 1'b0;
    end else begin
      if (wr_acc) wptr_d = wptr_q + PtrOne;
      if (rd_acc) rptr_d = rptr_q + PtrOne;
      // A new error event beats a simultaneous clear.
      ovf_d = (ovf_q & ~err_clr_i) | (wr_en_i & full);
      udf_d = (udf_q & ~err_clr_i) | (rd_en_i & empty);
    end
  end

  // Pointer and error flag registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
      ovf_q  <= 1'b0;
      udf_q  <= 1'b0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      ovf_q  <= ovf_d;
      udf_q  <= udf_d;
    end
  end

  // Storage array, intentionally not reset.
  always_ff @(posedge clk) begin
    if (wr_acc) mem_q[waddr] <= wr_data_i;
  end

  if (FWFT != 0) begin : g_fwft
    // Head word is presented directly; valid whenever something is stored.
    always_comb begin
      rd_data_o  = mem_q[raddr];
      rd_valid_o = ~empty;
    end
  end else begin : g_reg
    logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
    logic                  rd_valid_q;

    // Capture the head word on an accepted read; hold it otherwise.
    always_comb begin
      rd_data_d = rd_data_q;
      if (rd_acc) rd_data_d = mem_q[raddr];
    end

    // Registered read port; valid is a one-cycle pulse per accepted read.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        rd_data_q  <= '0;
        rd_valid_q <= 1'b0;
      end else begin
        rd_data_q  <= rd_data_d;
        rd_valid_q <= rd_acc;
      end
    end

    always_comb begin
      rd_data_o  = rd_data_q;
      rd_valid_o = rd_valid_q;
    end
  end

  // Status outputs.
  always_comb begin
    full_o         = full;
    empty_o        = empty;
    almost_full_o  = (count >= AfullCnt);
    almost_empty_o = (count <= AemptyCnt);
    count_o        = count;
    overflow_o     = ovf_q;
    underflow_o    = udf_q;
  end

endmodule
